// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the decode-side hazard sequencer.
//   state_e  : FSM states (encodings kept from the original RUN/LD_STALL/MEM_WAIT/FAULT)
//   ctrl_t   : bundle of the five pipeline control outputs
//   load_use : load-use hazard detect between the ID operands and the EX load
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } state_e;

  // bub_cnt covers LOAD_BUBBLES up to 7; wait_cnt covers MEM_TIMEOUT up to 255
  localparam int unsigned BUB_W  = 3;
  localparam int unsigned WAIT_W = 8;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic ctrl_muxsel;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 5'b11010;  // normal flow
  localparam ctrl_t CTRL_FREEZE = 5'b00011;  // whole pipe held, control passed through
  localparam ctrl_t CTRL_FLUSH  = 5'b11100;  // taken branch: NOP into IF/ID, bubble into ID/EX
  localparam ctrl_t CTRL_BUBBLE = 5'b00000;  // hold PC and IF/ID, bubble into ID/EX
  localparam ctrl_t CTRL_OFF    = 5'b00000;  // held in reset

  function automatic logic load_use(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2,
    input logic [4:0] ex_rd,
    input logic       ex_memread
  );
    return ex_memread && (ex_rd != '0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side hazard interface.
//   master : pipeline side, drives operand/EX/memory status, receives controls
//   slave  : hazard_stall_ctrl, receives status, drives enables/flush/freeze,
//            the sticky timeout flag and the stall performance counter
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             ctrl_muxsel;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           branch_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, ctrl_muxsel, pipe_freeze,
           mem_timeout, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           branch_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, ctrl_muxsel, pipe_freeze,
           mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall performance counter.
//   clk, rst : clock, async active-high reset
//   inc      : count this cycle
//   count    : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32 core: load-use bubbles,
// taken-branch flush, data-memory wait freeze and a sticky memory timeout.
//   clk  : core clock
//   rst  : async reset, active-high; forces all enables low while asserted
//   bus  : hazard_stall_ctrl_if slave (ID/EX operand info, branch, mem_busy in;
//          pc_write, if_id_write, if_id_flush, ctrl_muxsel, pipe_freeze,
//          mem_timeout, stall_count out)
// Outputs are combinational from state and inputs so stalls act in the same cycle.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  state_e             state, state_nxt;
  state_e             ret_state, ret_nxt;
  state_e             eff_state;
  logic [BUB_W-1:0]   bub_cnt, bub_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  ctrl_t              ctrl;
  logic               hazard;
  logic [CNT_W-1:0]   stall_cnt;

  assign hazard = load_use(bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2,
                           bus.ex_rd, bus.ex_memread);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      bub_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      bub_cnt   <= bub_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  always_comb begin
    ctrl      = CTRL_RUN;
    state_nxt = state;
    ret_nxt   = ret_state;
    bub_nxt   = bub_cnt;
    wait_nxt  = wait_cnt;
    eff_state = state;

    // The cycle mem_busy drops is handled by the state being returned to, so
    // the release cycle already carries that state's bubble/flush decision.
    if ((state == MEM_WAIT) && !bus.mem_busy) begin
      eff_state = ret_state;
      state_nxt = ret_state;
      wait_nxt  = '0;
    end

    unique case (eff_state)
      RUN: begin
        if (bus.mem_busy) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MEM_WAIT;
          ret_nxt   = RUN;
          wait_nxt  = WAIT_W'(1);   // this cycle is the first busy cycle
        end else if (bus.branch_taken) begin
          ctrl = CTRL_FLUSH;
        end else if (hazard) begin
          ctrl      = CTRL_BUBBLE;
          bub_nxt   = BUB_W'(LOAD_BUBBLES - 1);
          state_nxt = (LOAD_BUBBLES > 1) ? LD_STALL : RUN;
        end
      end
      LD_STALL: begin
        if (bus.mem_busy) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MEM_WAIT;
          ret_nxt   = LD_STALL;
          wait_nxt  = WAIT_W'(1);
        end else if (bus.branch_taken) begin
          ctrl      = CTRL_FLUSH;
          bub_nxt   = '0;
          state_nxt = RUN;
        end else begin
          ctrl      = CTRL_BUBBLE;
          bub_nxt   = (bub_cnt <= BUB_W'(1)) ? '0 : bub_cnt - 1'b1;
          state_nxt = (bub_cnt <= BUB_W'(1)) ? RUN : LD_STALL;
        end
      end
      MEM_WAIT: begin
        // only reached with mem_busy high; bub_cnt is left untouched
        ctrl = CTRL_FREEZE;
        if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          state_nxt = FAULT;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      FAULT: begin
        ctrl = CTRL_FREEZE;
      end
    endcase

    if (rst) begin
      ctrl = CTRL_OFF;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_write && !rst),
    .count (stall_cnt)
  );

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.if_id_write = ctrl.if_id_write;
  assign bus.if_id_flush = ctrl.if_id_flush;
  assign bus.ctrl_muxsel = ctrl.ctrl_muxsel;
  assign bus.pipe_freeze = ctrl.pipe_freeze;
  assign bus.mem_timeout = (state == FAULT);
  assign bus.stall_count = stall_cnt;

endmodule
